reg_scoreboard: RTL

//  Per-register pending-write scoreboard for the in-order core pipeline; generalised successor of the fixed 8-reg/3-bit invalid tracker.

---
 rtl/reg_scoreboard.sv | 111 +++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: decode posts destination writes with a latency class,
// per-register down-counters report source-operand hazards for two read ports.
module reg_scoreboard #(
   parameter int unsigned NREGS    = 8,
   parameter int unsigned AW       = $clog2(NREGS),
   parameter int unsigned LAT_ALU  = 2,
   parameter int unsigned LAT_MEM  = 1,
   parameter int unsigned LAT_LONG = 0,
   parameter int unsigned CW       = 3,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_waiting,
   input  logic                  flush_decode,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_rd,
   input  logic [1:0]            issue_cls,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_rd,
   input  logic [AW-1:0]         rs_a,
   input  logic [AW-1:0]         rs_b,
   input  logic                  rs_a_en,
   input  logic                  rs_b_en,
   output logic                  hazard_a,
   output logic                  hazard_b,
   output logic                  hazard,
   output logic [NREGS-1:0]      busy,
   output logic [NREGS*CW-1:0]   cnt_flat
);

   localparam int unsigned SENT_I = (1 << CW) - 1;
   localparam int unsigned NPAD   = 1 << AW;
   localparam logic [CW-1:0] SENT = {CW{1'b1}};

   localparam logic [1:0] CLS_MEM  = 2'd1;
   localparam logic [1:0] CLS_LONG = 2'd2;

   // Latencies must stay below the wait-for-writeback sentinel
   if (LAT_ALU >= SENT_I || LAT_MEM >= SENT_I || LAT_LONG >= SENT_I) begin : g_lat_check
      $error("reg_scoreboard: latency parameter collides with sentinel");
   end

   logic [CW-1:0]   cnt_q [NREGS];
   logic [CW-1:0]   cnt_d [NREGS];
   logic [CW-1:0]   load_val;
   logic            issue_ok;
   logic [NPAD-1:0] busy_pad;

   // Count loaded for the issuing destination; reserved class behaves as ALU
   always_comb begin
      load_val = CW'(LAT_ALU);
      case (issue_cls)
         CLS_MEM:  load_val = CW'(LAT_MEM);
         CLS_LONG: load_val = (LAT_LONG == 0) ? SENT : CW'(LAT_LONG);
         default:  load_val = CW'(LAT_ALU);
      endcase
   end

   always_comb begin
      issue_ok = issue_valid & ~flush_decode & ~memory_waiting
                 & ~(ZERO_REG & (issue_rd == AW'(0)));
   end

   // Issue beats writeback clear; writeback clear on a sentinel beats the stall hold
   always_comb begin
      for (int unsigned r = 0; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (issue_ok && (issue_rd == AW'(r))) begin
            cnt_d[r] = load_val;
         end else if (wb_valid && (wb_rd == AW'(r)) && (cnt_q[r] == SENT)) begin
            cnt_d[r] = '0;
         end else if (!memory_waiting && (cnt_q[r] != '0) && (cnt_q[r] != SENT)) begin
            cnt_d[r] = cnt_q[r] - CW'(1);
         end
         if (ZERO_REG && (r == 0)) begin
            cnt_d[r] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   always_comb begin
      busy     = '0;
      cnt_flat = '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
         busy[r]              = (cnt_q[r] != '0);
         cnt_flat[r*CW +: CW] = cnt_q[r];
      end
   end

   // Out-of-range source addresses (non power-of-two NREGS) read as not busy
   always_comb begin
      busy_pad = NPAD'(busy);
      hazard_a = rs_a_en & busy_pad[rs_a];
      hazard_b = rs_b_en & busy_pad[rs_b];
      hazard   = hazard_a | hazard_b;
   end

endmodule
